// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the data-memory access controller.
package mem_ctrl_pkg;
  localparam int AW_DEF    = 9;
  localparam int DW_DEF    = 16;
  localparam int BLW_DEF   = 4;
  localparam int MEM_WORDS = 512;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_t;
endpackage

// File: rtl/mem_rd_pipe.sv
// Valid shift register that tags each issued read address and flags its data beat
// RD_LAT cycles later; drained_o says the pipe will be empty after this edge.
module mem_rd_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic issue_i,
  output logic beat_o,
  output logic drained_o
);
  logic [RD_LAT-1:0] vld_q, vld_d;

  always_comb begin
    vld_d    = '0;
    vld_d[0] = issue_i;
    for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  assign beat_o    = vld_q[RD_LAT-1];
  assign drained_o = (vld_d == '0);
endmodule

// File: rtl/mem_access_ctrl.sv
// Valid/ready single and burst access controller for the 512x16 data memory.
// Define MEM_CTRL_BOUND_CHECK_EN to reject bursts running past the last word (pulses err).
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int BLW    = BLW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_we,
  input  logic [AW-1:0]  req_addr,
  input  logic [BLW-1:0] req_blen,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic [DW-1:0]  wr_data,
  output logic           rd_valid,
  output logic [DW-1:0]  rd_data,
  output logic           done,
  output logic           err,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_din,
  input  logic [DW-1:0]  mem_dout
);
  state_t         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [BLW-1:0] blen_q, blen_d, cnt_q, cnt_d;
  logic           issue, last_beat, pipe_beat, pipe_drained, reject;

`ifdef MEM_CTRL_BOUND_CHECK_EN
  logic [AW:0] end_addr;
  logic        err_q;

  // Carry out of the end address means the burst would run past the top word.
  assign end_addr = {1'b0, req_addr} + (AW+1)'(req_blen);
  assign reject   = end_addr[AW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (state_q == IDLE) && req_valid && reject;
  end
  assign err = err_q;
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  assign last_beat = (cnt_q == blen_q);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    blen_d    = blen_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_din   = '0;
    issue     = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !reject) begin
          addr_d  = req_addr;
          blen_d  = req_blen;
          cnt_d   = '0;
          state_d = req_we ? WR : RD;
        end
      end
      WR: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          mem_we  = 1'b1;
          mem_din = wr_data;
          addr_d  = addr_q + AW'(1);
          cnt_d   = cnt_q + BLW'(1);
          if (last_beat) state_d = FIN;
        end
      end
      RD: begin
        issue  = 1'b1;
        addr_d = addr_q + AW'(1);
        cnt_d  = cnt_q + BLW'(1);
        if (last_beat) state_d = DRAIN;
      end
      DRAIN: if (pipe_drained) state_d = FIN;
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      blen_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      blen_q  <= blen_d;
      cnt_q   <= cnt_d;
    end
  end

  mem_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .issue_i   (issue),
    .beat_o    (pipe_beat),
    .drained_o (pipe_drained)
  );

  assign mem_addr = addr_q;
  assign rd_valid = pipe_beat;
  assign rd_data  = pipe_beat ? mem_dout : '0;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three instances (RD_LAT=1,2,3) share one stimulus stream.
module tb_mem_access_ctrl;
  localparam int NI = 3;
`ifdef MEM_CTRL_BOUND_CHECK_EN
  localparam bit MEM_BC = 1'b1;
`else
  localparam bit MEM_BC = 1'b0;
`endif

  logic        clk, rst;
  logic        req_valid, req_we, wr_valid;
  logic [8:0]  req_addr;
  logic [3:0]  req_blen;
  logic [15:0] wr_data;
  logic        req_ready [NI];
  logic        wr_ready  [NI];
  logic        rd_valid  [NI];
  logic        done      [NI];
  logic        err       [NI];
  logic        mem_we    [NI];
  logic [8:0]  mem_addr  [NI];
  logic [15:0] rd_data   [NI];
  logic [15:0] mem_din   [NI];
  logic [15:0] mem_dout  [NI];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  logic [15:0] model [512];
  int          rexp_a [$];
  logic [15:0] rexp_d [$];
  int          wexp_a [$];
  logic [15:0] wexp_d [$];

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int L = g + 1;
    logic [15:0] ram   [512];
    logic [15:0] dpipe [L];
    logic [8:0]  ahist [4];
    // cnt: 0 mem_we beats, 1 rd beats, 2 dones, 3 errs, 4 last done cycle, 5 rd ptr, 6 wr ptr
    int cnt [7] = '{default: 0};

    mem_access_ctrl #(.AW(9), .DW(16), .BLW(4), .RD_LAT(L)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready[g]), .req_we(req_we),
      .req_addr(req_addr), .req_blen(req_blen),
      .wr_valid(wr_valid), .wr_ready(wr_ready[g]), .wr_data(wr_data),
      .rd_valid(rd_valid[g]), .rd_data(rd_data[g]),
      .done(done[g]), .err(err[g]),
      .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_din(mem_din[g]),
      .mem_dout(mem_dout[g])
    );

    always @(posedge clk) begin
      if (mem_we[g]) ram[mem_addr[g]] <= mem_din[g];
      dpipe[0] <= ram[mem_addr[g]];
      for (int i = 1; i < L; i++) dpipe[i] <= dpipe[i-1];
    end
    assign mem_dout[g] = dpipe[L-1];

    initial forever begin
      @(negedge clk);
      if (mem_we[g]) begin
        cnt[0]++;
        if (cnt[6] >= wexp_a.size()) chk("wr_extra", 1, 0);
        else begin
          chk("wr_addr", int'(mem_addr[g]), wexp_a[cnt[6]]);
          chk("wr_data", int'(mem_din[g]), int'(wexp_d[cnt[6]]));
          cnt[6]++;
        end
      end
      if (rd_valid[g]) begin
        cnt[1]++;
        if (cnt[5] >= rexp_a.size()) chk("rd_extra", 1, 0);
        else begin
          chk("rd_lat_addr", int'(ahist[L-1]), rexp_a[cnt[5]]);
          chk("rd_data", int'(rd_data[g]), int'(rexp_d[cnt[5]]));
          cnt[5]++;
        end
      end
      if (done[g]) begin
        cnt[2]++;
        cnt[4] = cyc;
      end
      if (err[g]) cnt[3]++;
      for (int i = 3; i > 0; i--) ahist[i] = ahist[i-1];
      ahist[0] = mem_addr[g];
    end
  end

  function automatic int get(int g, int k);
    case (g)
      0:       return gi[0].cnt[k];
      1:       return gi[1].cnt[k];
      default: return gi[2].cnt[k];
    endcase
  endfunction

  function automatic bit is_rej(logic [8:0] a, logic [3:0] bl);
    return MEM_BC && ((int'(a) + int'(bl)) > 511);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(bit we, logic [8:0] a, logic [3:0] bl);
    chk("rdy_before_req", int'(req_ready[0]), 1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_blen = bl;
    tick();
    acc_cyc = cyc;
    req_valid = 1'b0; req_we = ~we; req_addr = ~a; req_blen = ~bl;
  endtask

  task automatic do_write(logic [8:0] a, logic [3:0] bl, logic [15:0] d0, int stall);
    logic [8:0] wa;
    accept(1'b1, a, bl);
    if (is_rej(a, bl)) return;
    for (int i = 0; i <= int'(bl); i++) begin
      if (i == stall) begin
        wr_valid = 1'b0;
        for (int s = 0; s < 2; s++) begin
          chk("wr_rdy_stall", int'(wr_ready[0]), 1);
          tick();
        end
      end
      wa = a + 9'(i);
      wexp_a.push_back(int'(wa));
      wexp_d.push_back(d0 + 16'(i));
      model[wa] = d0 + 16'(i);
      wr_valid = 1'b1;
      wr_data  = d0 + 16'(i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic do_read(logic [8:0] a, logic [3:0] bl);
    logic [8:0] ra;
    if (!is_rej(a, bl))
      for (int i = 0; i <= int'(bl); i++) begin
        ra = a + 9'(i);
        rexp_a.push_back(int'(ra));
        rexp_d.push_back(model[ra]);
      end
    accept(1'b0, a, bl);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(req_ready[0] && req_ready[1] && req_ready[2]) && k < 60) begin
      tick();
      k++;
    end
    if (k >= 60) chk("idle_timeout", k, 0);
    tick();
    tick();
  endtask

  typedef struct {
    bit          we;
    logic [8:0]  addr;
    logic [3:0]  blen;
    logic [15:0] d0;
    int          stall;
    int          e_we;
    int          e_rdv;
    int          e_done;
    int          e_err;
    int          e_lat;
  } vec_t;

  vec_t tv [8];
  int s_we, s_rdv, s_done, s_err;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // e_lat: cycles from the accept edge to done for RD_LAT=1 (reads add RD_LAT-1).
    tv[0] = '{1'b1, 9'h000, 4'd0, 16'hABCD, -1, 1, 0, 1, 0, 1};
    tv[1] = '{1'b0, 9'h000, 4'd0, 16'h0000, -1, 0, 1, 1, 0, 2};
    tv[2] = '{1'b1, 9'h010, 4'd9, 16'h0010,  3, 10, 0, 1, 0, 12};
    tv[3] = '{1'b0, 9'h010, 4'd9, 16'h0000, -1, 0, 10, 1, 0, 11};
    if (MEM_BC) begin
      tv[4] = '{1'b1, 9'h1FE, 4'd3, 16'h7000, -1, 0, 0, 0, 1, 0};
      tv[5] = '{1'b0, 9'h1FE, 4'd3, 16'h0000, -1, 0, 0, 0, 1, 0};
    end else begin
      tv[4] = '{1'b1, 9'h1FE, 4'd3, 16'h7000, -1, 4, 0, 1, 0, 4};
      tv[5] = '{1'b0, 9'h1FE, 4'd3, 16'h0000, -1, 0, 4, 1, 0, 5};
    end
    tv[6] = '{1'b1, 9'h080, 4'd7, 16'h1100, -1, 8, 0, 1, 0, 8};
    tv[7] = '{1'b1, 9'h100, 4'd15, 16'h2000, -1, 16, 0, 1, 0, 16};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_blen = '0;
    wr_valid = 1'b0; wr_data = '0;
    tick();
    chk("rst_req_ready", int'(req_ready[0]), 1);
    chk("rst_wr_ready", int'(wr_ready[0]), 0);
    chk("rst_rd_valid", int'(rd_valid[0]), 0);
    chk("rst_rd_data", int'(rd_data[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_err", int'(err[0]), 0);
    chk("rst_mem_we", int'(mem_we[0]), 0);
    chk("rst_mem_addr", int'(mem_addr[0]), 0);
    chk("rst_mem_din", int'(mem_din[0]), 0);
    tick();
    rst = 1'b0;
    tick();

    for (int v = 0; v < 8; v++) begin
      s_we = get(0, 0); s_rdv = get(0, 1); s_done = get(0, 2); s_err = get(0, 3);
      if (tv[v].we) do_write(tv[v].addr, tv[v].blen, tv[v].d0, tv[v].stall);
      else          do_read(tv[v].addr, tv[v].blen);
      wait_idle();
      chk("vec_we_cnt", get(0, 0) - s_we, tv[v].e_we);
      chk("vec_rdv_cnt", get(0, 1) - s_rdv, tv[v].e_rdv);
      chk("vec_done_cnt", get(0, 2) - s_done, tv[v].e_done);
      chk("vec_err_cnt", get(0, 3) - s_err, tv[v].e_err);
      if (tv[v].e_err != 0) chk("vec_rdy_after_rej", int'(req_ready[0]), 1);
      if (tv[v].e_done != 0)
        for (int g = 0; g < NI; g++)
          chk("vec_done_lat", get(g, 4) - acc_cyc, tv[v].e_lat + (tv[v].we ? 0 : g));
    end

    // 16-beat read with a competing request and stray write beats held throughout
    s_we = get(0, 0); s_rdv = get(0, 1); s_done = get(0, 2);
    do_read(9'h100, 4'd15);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h000; req_blen = 4'd0;
    wr_valid = 1'b1; wr_data = 16'hBAD0;
    for (int k = 0; k < 16; k++) begin
      chk("busy_req_ready", int'(req_ready[0]), 0);
      tick();
    end
    req_valid = 1'b0; wr_valid = 1'b0;
    wait_idle();
    chk("busy_rdv_cnt", get(0, 1) - s_rdv, 16);
    chk("busy_we_cnt", get(0, 0) - s_we, 0);
    chk("busy_done_cnt", get(0, 2) - s_done, 1);
    chk("busy_done_lat", get(0, 4) - acc_cyc, 17);

    // reset after four beats of an eight-beat write
    s_done = get(0, 2);
    accept(1'b1, 9'h080, 4'd7);
    for (int i = 0; i < 4; i++) begin
      wexp_a.push_back(16'h080 + i);
      wexp_d.push_back(16'hDEAD);
      model[9'h080 + 9'(i)] = 16'hDEAD;
      wr_valid = 1'b1;
      wr_data  = 16'hDEAD;
      tick();
    end
    rst = 1'b1;
    #1;
    chk("midrst_mem_we", int'(mem_we[0]), 0);
    chk("midrst_req_ready", int'(req_ready[0]), 1);
    chk("midrst_wr_ready", int'(wr_ready[0]), 0);
    chk("midrst_mem_addr", int'(mem_addr[0]), 0);
    chk("midrst_mem_din", int'(mem_din[0]), 0);
    wr_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_no_done", get(0, 2) - s_done, 0);
    s_rdv = get(0, 1);
    do_read(9'h080, 4'd7);
    wait_idle();
    chk("midrst_rdv_cnt", get(0, 1) - s_rdv, 8);
    chk("midrst_beat5_word", int'(model[9'h084]), 16'h1104);

    for (int g = 0; g < NI; g++) begin
      chk("all_rd_beats", get(g, 5), rexp_a.size());
      chk("all_wr_beats", get(g, 6), wexp_a.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
